// File: rtl/sfp_acc_row_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sfp_acc_row_if : psum-in / result-out valid-ready bundle for sfp_acc_row
// Revision: 1.0
// ---------------------------------------------------------------------------
interface sfp_acc_row_if #(
    parameter int psum_bw = 16,
    parameter int col     = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [psum_bw*col-1:0]   in;
    logic                     out_valid;
    logic                     out_ready;
    logic [psum_bw*col-1:0]   out;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out
    );
endinterface
`default_nettype wire

// File: rtl/sfp_acc_row.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sfp_acc_row : per-lane psum accumulate, activation (pass/ReLU/leaky), saturate
// Revision: 1.0
// ---------------------------------------------------------------------------
module sfp_acc_row #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int acc_bw  = psum_bw + 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic [7:0]   cfg_acc_len,
    input  wire logic [1:0]   cfg_mode,
    input  wire logic [3:0]   cfg_shift,
    sfp_acc_row_if.slave      bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [acc_bw-1:0] SAT_MAX =
        {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
    localparam logic signed [acc_bw-1:0] SAT_MIN =
        {{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

    state_t                   state;
    state_t                   state_nx;
    logic [7:0]               len_q;
    logic [1:0]               mode_q;
    logic [3:0]               shift_q;
    logic [7:0]               count;
    logic [7:0]               len_eff;
    logic [1:0]               mode_eff;
    logic [3:0]               shift_eff;
    logic [7:0]               count_nx;
    logic                     accept;
    logic                     last_beat;
    logic [psum_bw*col-1:0]   res_vec;
    logic [psum_bw*col-1:0]   out_q;

    assign bus.in_ready  = reset && (state != DONE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign busy          = (state != IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    // In IDLE the live config applies to the first beat; afterwards the latched copy.
    always_comb begin
        len_eff   = len_q;
        mode_eff  = mode_q;
        shift_eff = shift_q;
        if (state == IDLE) begin
            len_eff   = (cfg_acc_len == 8'd0) ? 8'd1 : cfg_acc_len;
            mode_eff  = cfg_mode;
            shift_eff = cfg_shift;
        end
    end

    assign count_nx  = (state == IDLE) ? 8'd1 : count + 8'd1;
    assign last_beat = accept && (count_nx == len_eff);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = last_beat ? DONE : ACC;
            ACC:     if (last_beat) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            len_q   <= 8'd0;
            mode_q  <= 2'd0;
            shift_q <= 4'd0;
            count   <= 8'd0;
            out_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept && state == IDLE) begin
                len_q   <= len_eff;
                mode_q  <= mode_eff;
                shift_q <= shift_eff;
            end
            if (accept) count <= count_nx;
            if (last_beat) out_q <= res_vec;
        end
    end

    for (genvar i = 0; i < col; i++) begin : g_lane
        logic signed [psum_bw-1:0] lane_raw;
        logic signed [acc_bw-1:0]  lane_ext;
        logic signed [acc_bw-1:0]  acc;
        logic signed [acc_bw-1:0]  sum;
        logic signed [acc_bw-1:0]  act;

        assign lane_raw = bus.in[i*psum_bw +: psum_bw];
        assign lane_ext = {{(acc_bw-psum_bw){lane_raw[psum_bw-1]}}, lane_raw};
        // The first beat of a burst overwrites rather than adds to old contents.
        assign sum      = (state == IDLE) ? lane_ext : acc + lane_ext;

        always_comb begin
            act = sum;
            if (sum[acc_bw-1]) begin
                if (mode_eff == 2'd1)      act = '0;
                else if (mode_eff == 2'd2) act = sum >>> shift_eff;
            end
        end

        assign res_vec[i*psum_bw +: psum_bw] =
            (act > SAT_MAX) ? SAT_MAX[psum_bw-1:0] :
            (act < SAT_MIN) ? SAT_MIN[psum_bw-1:0] :
                              act[psum_bw-1:0];

        always_ff @(posedge clk) begin
            if (!reset)      acc <= '0;
            else if (accept) acc <= sum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sfp_acc_row.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sfp_acc_row : scenario tasks with a queue scoreboard for sfp_acc_row
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sfp_acc_row;
    localparam int PB = 16;
    localparam int NC = 8;
    localparam int W  = PB * NC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cfg_acc_len;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_shift;
    logic       busy;

    sfp_acc_row_if #(.psum_bw(PB), .col(NC)) bus ();

    sfp_acc_row #(.psum_bw(PB), .col(NC), .acc_bw(PB + 8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_acc_len (cfg_acc_len),
        .cfg_mode    (cfg_mode),
        .cfg_shift   (cfg_shift),
        .bus         (bus.slave),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] expv;
    logic [W-1:0] held;
    bit           ok;

    function automatic logic [W-1:0] mk3(input int a, input int b, input int c);
        logic [W-1:0] v;
        v = '0;
        v[15:0]  = a[15:0];
        v[31:16] = b[15:0];
        v[47:32] = c[15:0];
        return v;
    endfunction

    // Reference: activation then clamp to the signed 16-bit range.
    function automatic int model(input int s, input int mode, input int sh);
        int f;
        f = s;
        if (mode == 1 && s < 0)      f = 0;
        else if (mode == 2 && s < 0) f = s >>> sh;
        if (f > 32767)  f = 32767;
        if (f < -32768) f = -32768;
        return f;
    endfunction

    task automatic send_beat(input logic [W-1:0] v);
        bus.in_valid = 1'b1;
        bus.in       = v;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in = '0;
        cfg_acc_len = 8'd1; cfg_mode = 2'd0; cfg_shift = 4'd0;
        repeat (3) @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (bus.out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.out); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_single_pass();
        cfg_acc_len = 8'd1; cfg_mode = 2'd0; cfg_shift = 4'd0;
        exp_q.push_back(mk3(model(100, 0, 0), model(-5, 0, 0), 0));
        send_beat(mk3(100, -5, 0));
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_latency out_valid got=%b exp=1", bus.out_valid); end
        expv = exp_q.pop_front();
        total++; if (bus.out !== expv) begin bad++; $display("FAIL single_out got=%h exp=%h", bus.out, expv); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL single_done_in_ready got=%b exp=0", bus.in_ready); end
        release_out();
        total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_release valid/busy got=%b%b exp=00", bus.out_valid, busy); end
    endtask

    task automatic test_relu_gaps();
        int a[4] = '{10, -3, 7, 1};
        int s0 = 0;
        int s1 = 0;
        cfg_acc_len = 8'd4; cfg_mode = 2'd1; cfg_shift = 4'd0;
        for (int b = 0; b < 4; b++) begin
            s0 += a[b];
            s1 += -20;
            if (b == 3) exp_q.push_back(mk3(model(s0, 1, 0), model(s1, 1, 0), 0));
            send_beat(mk3(a[b], -20, 0));
            // Disturb config mid-burst; the latched copy must be used.
            if (b == 0) begin cfg_acc_len = 8'd1; cfg_mode = 2'd0; end
            if (b < 3) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL relu_early_valid beat=%0d got=%b exp=0", b, bus.out_valid); end
                repeat (2) begin
                    @(negedge clk);
                    total++; if (busy !== 1'b1) begin bad++; $display("FAIL relu_busy beat=%0d got=%b exp=1", b, busy); end
                end
            end
        end
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL relu_timeout got=no_valid exp=valid"); end
        else begin
            expv = exp_q.pop_front();
            if (bus.out !== expv) begin bad++; $display("FAIL relu_out got=%h exp=%h", bus.out, expv); end
        end
        release_out();
    endtask

    task automatic test_saturation();
        cfg_acc_len = 8'd4; cfg_mode = 2'd0; cfg_shift = 4'd0;
        exp_q.push_back(mk3(model(120000, 0, 0), model(-120000, 0, 0), 0));
        for (int b = 0; b < 4; b++) begin
            send_beat(mk3(30000, -30000, 0));
            if (b == 2) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sat_early_valid got=%b exp=0", bus.out_valid); end
            end
        end
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL sat_timeout got=no_valid exp=valid"); end
        else begin
            expv = exp_q.pop_front();
            if (bus.out !== expv) begin bad++; $display("FAIL sat_out got=%h exp=%h", bus.out, expv); end
        end
        release_out();
    endtask

    task automatic test_leaky();
        cfg_acc_len = 8'd1; cfg_mode = 2'd2; cfg_shift = 4'd2;
        exp_q.push_back(mk3(model(-100, 2, 2), model(-7, 2, 2), model(9, 2, 2)));
        send_beat(mk3(-100, -7, 9));
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL leaky_timeout got=no_valid exp=valid"); end
        else begin
            expv = exp_q.pop_front();
            if (bus.out !== expv) begin bad++; $display("FAIL leaky_out got=%h exp=%h", bus.out, expv); end
        end
        release_out();
    endtask

    task automatic test_backpressure();
        cfg_acc_len = 8'd2; cfg_mode = 2'd0; cfg_shift = 4'd0;
        exp_q.push_back(mk3(model(1024, 0, 0), model(-1024, 0, 0), model(0, 0, 0)));
        send_beat(mk3(1000, -1000, 5));
        send_beat(mk3(24, -24, -5));
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout got=no_valid exp=valid"); end
        else begin
            expv = exp_q.pop_front();
            if (bus.out !== expv) begin bad++; $display("FAIL bp_out got=%h exp=%h", bus.out, expv); end
        end
        held = expv;
        bus.in_valid = 1'b1;
        bus.in = mk3(7777, 7777, 7777);
        repeat (5) begin
            @(negedge clk);
            total++; if (bus.out !== held) begin bad++; $display("FAIL bp_hold_out got=%h exp=%h", bus.out, held); end
            total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_ready/valid got=%b%b exp=01", bus.in_ready, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle valid/busy/ready got=%b%b%b exp=001", bus.out_valid, busy, bus.in_ready); end
        cfg_acc_len = 8'd1;
        exp_q.push_back(mk3(model(7, 0, 0), 0, 0));
        send_beat(mk3(7, 0, 0));
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_fresh_timeout got=no_valid exp=valid"); end
        else begin
            expv = exp_q.pop_front();
            if (bus.out !== expv) begin bad++; $display("FAIL bp_fresh_out got=%h exp=%h", bus.out, expv); end
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        cfg_acc_len = 8'd4; cfg_mode = 2'd0; cfg_shift = 4'd0;
        send_beat(mk3(50, 50, 50));
        send_beat(mk3(50, 50, 50));
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", busy); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_ctrl ready/valid/busy got=%b%b%b exp=000", bus.in_ready, bus.out_valid, busy); end
        total++; if (bus.out !== '0) begin bad++; $display("FAIL rmid_out got=%h exp=0", bus.out); end
        reset = 1'b1;
        cfg_acc_len = 8'd1;
        exp_q.push_back(mk3(model(3, 0, 0), 0, 0));
        send_beat(mk3(3, 0, 0));
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_timeout got=no_valid exp=valid"); end
        else begin
            expv = exp_q.pop_front();
            if (bus.out !== expv) begin bad++; $display("FAIL rmid_out_after got=%h exp=%h", bus.out, expv); end
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        int x;
        cfg_acc_len = 8'd0; cfg_mode = 2'd3; cfg_shift = 4'd5;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = '0;
            for (int l = 0; l < NC; l++) begin
                x = int'($urandom_range(0, 65535)) - 32768;
                v[l*PB +: PB] = x[15:0];
            end
            exp_q.push_back(v);
            send_beat(v);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, bus.out_valid); end
            expv = exp_q.pop_front();
            total++; if (bus.out !== expv) begin bad++; $display("FAIL b2b_out k=%0d got=%h exp=%h", k, bus.out, expv); end
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_bubble k=%0d valid/ready got=%b%b exp=01", k, bus.out_valid, bus.in_ready); end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_relu_gaps();
        test_saturation();
        test_leaky();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfp_acc_row.md
# sfp_acc_row

Parametrised special-function row that replaces the fixed accumulate-then-ReLU column slice at the systolic array output. Each of `col` lanes accumulates a programmable number of signed partial-sum beats in a widened accumulator, applies a selectable activation (pass, ReLU, leaky-shift), saturates back to `psum_bw`, and presents one registered result vector under a valid/ready handshake. It sits between the array's psum output and the output SRAM write path.

## Interface
- `psum_bw`, 16: signed partial-sum width, for both input and output lanes.
- `col`, 8: number of lanes.
- `acc_bw`, `psum_bw+8`: internal signed accumulator width. Must be ≥ `psum_bw+8`.
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cfg_acc_len`  in  8  beats per accumulation. 0 is treated as 1.
- `cfg_mode`  in  2  0 = pass, 1 = ReLU, 2 = leaky (negative values arithmetic-shifted right), 3 = reserved and behaves as pass.
- `cfg_shift`  in  4  leaky shift amount.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in`  in  `psum_bw*col`  lane i occupies `[psum_bw*(i+1)-1 : psum_bw*i]`. Signed.
- `out_valid`  out  1  result vector valid.
- `out_ready`  in  1  consumer accepts result.
- `out`  out  `psum_bw*col`  result vector, same lane packing as `in`.
- `busy`  out  1  high when state is not IDLE.

## Operation
- FSM states:
  - IDLE: accumulators hold no data; `in_ready`=1.
  - ACC: accumulation in progress; `in_ready`=1.
  - DONE: `out_valid`=1; `in_ready`=0.
- A beat is accepted when `in_valid && in_ready`.
- IDLE + accepted beat:
  - Latch `cfg_acc_len`, `cfg_mode` and `cfg_shift`. The latched values stay fixed until the next IDLE.
  - Load each accumulator with the sign-extended lane value. Do not add to stale contents.
  - Set the beat count to 1.
  - If the latched length is ≤1, go to DONE. Otherwise go to ACC.
- ACC + accepted beat:
  - Add the sign-extended lane value into each accumulator and increment the count.
  - When the count equals the latched length, go to DONE.
- Result register, loaded on the final accepted beat:
  - Compute `s` = accumulator including the final beat.
  - Apply the function:
    - pass: `f = s`.
    - ReLU: `f = (s<0) ? 0 : s`.
    - leaky: `f = (s<0) ? (s >>> shift) : s`. This is an arithmetic shift, so it rounds toward −∞.
  - Saturate `f` to [−2^(psum_bw−1), 2^(psum_bw−1)−1].
- Accumulator overflow beyond `acc_bw` wraps in two's complement. It is unreachable with `acc_bw` ≥ `psum_bw+8` and length ≤255.
- DONE:
  - `out` and `out_valid` hold stable until `out_ready`=1.
  - On that edge go to IDLE. `out_valid` is 0 the next cycle.
  - `in_valid` is ignored while in DONE.
- Config inputs are don't-care outside the IDLE acceptance edge.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out`=0, `busy`=0, accumulators and count = 0.
- `in_ready` is forced to 0 while `reset` is low.
- `reset` low at any point, including mid-ACC or in DONE, discards everything on that edge.
- Latency: the final beat accepted at edge N gives `out_valid`=1 and a valid `out` from edge N.
- Throughput: one result per (len + 1) cycles minimum. There is one bubble cycle in DONE even when `out_ready`=1.
- `in_ready` and `busy` are combinational from state and reset only. There is no path from `in_valid` or `out_ready` to `in_ready`.
- Beats with `in_valid`=0 during ACC leave the accumulators and count unchanged. Gaps are allowed.

## Test plan
- Single beat, pass:
  - Stimulus: len=1, mode=0, lane0=100, lane1=−5, other lanes 0.
  - Required: `out_valid` one edge after acceptance; lane0=100, lane1=−5 (0xFFFB), other lanes 0.
- Four beats, ReLU, with gaps:
  - Stimulus: len=4, mode=1; lane0 beats 10, −3, 7, 1; lane1 −20 ×4; 2-cycle `in_valid` gaps.
  - Required: lane0=15, lane1=0; `busy` high throughout.
- Saturation:
  - Stimulus: len=4, mode=0; lane0 30000 ×4 (sum 120000); lane1 −30000 ×4.
  - Required: lane0=32767, lane1=−32768.
- Leaky shift:
  - Stimulus: len=1, mode=2, shift=2; lane0=−100, lane1=−7, lane2=9.
  - Required: lane0=−25, lane1=−2, lane2=9.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1.
  - Required: `out` is stable, `in_ready`=0 and no beat is consumed. After `out_ready`=1, IDLE is reached the next edge and the following burst starts fresh.
- Reset mid-accumulation:
  - Stimulus: len=4; assert `reset` low after 2 beats; then send a new len=1 burst with lane0=3.
  - Required: all outputs reach their reset values, then the result is lane0=3 with no residue from the first burst.
